// File: rtl/median_window_buf_if.sv
// Sample-in / window-out bundle between the sample source, the window buffer and the median sorter.
interface median_window_buf_if #(
    parameter int unsigned DATA_W = 6
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              flush;
    logic              out_valid;
    logic [DATA_W-1:0] out_num0;
    logic [DATA_W-1:0] out_num1;
    logic [DATA_W-1:0] out_num2;
    logic [DATA_W-1:0] out_num3;
    logic [DATA_W-1:0] out_num4;
    logic [2:0]        fill_cnt;

    // Sample source side: drives samples and flush, observes the window.
    modport master (
        output in_valid, in_data, flush,
        input  out_valid, out_num0, out_num1, out_num2, out_num3, out_num4, fill_cnt
    );

    // Window buffer side.
    modport slave (
        input  in_valid, in_data, flush,
        output out_valid, out_num0, out_num1, out_num2, out_num3, out_num4, fill_cnt
    );
endinterface

// File: rtl/median_window_buf.sv
// 5-deep sliding sample window feeding the 5-input median sorter.
// out_num0 is the oldest entry, out_num4 the newest; out_valid strobes once per complete window.
// Optional macro MEDIAN_EDGE_REPLICATE_EN: the first sample after reset/flush fills all five
// entries, so a window is produced for every sample from the first one.
module median_window_buf #(
    parameter int unsigned DATA_W = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    median_window_buf_if.slave   bus_io
);

    localparam int unsigned DEPTH = 5;
    localparam int unsigned CNT_W = 3;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEPTH - 1);

`ifdef MEDIAN_EDGE_REPLICATE_EN
    localparam bit REPLICATE = 1'b1;
`else
    localparam bit REPLICATE = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_FULL = 2'd2
    } state_e;

    state_e            state_q;
    state_e            state_d;
    logic [DATA_W-1:0] win_q   [DEPTH];
    logic [DATA_W-1:0] win_d   [DEPTH];
    logic [DATA_W-1:0] shift_c [DEPTH];
    logic [CNT_W-1:0]  fill_q;
    logic [CNT_W-1:0]  fill_d;
    logic              valid_q;
    logic              valid_d;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: flush restarts the window, possibly with the concurrent sample as its first entry.
    always_comb begin
        state_d = state_q;
        if (bus_io.flush) begin
            if (bus_io.in_valid) begin
                state_d = REPLICATE ? ST_FULL : ST_FILL;
            end else begin
                state_d = ST_IDLE;
            end
        end else if (bus_io.in_valid) begin
            case (state_q)
                ST_IDLE: state_d = REPLICATE ? ST_FULL : ST_FILL;
                ST_FILL: if (fill_q == CNT_LAST) state_d = ST_FULL;
                ST_FULL: state_d = ST_FULL;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Window contents after an accepted sample: drop the oldest, append the newest.
    always_comb begin
        for (int i = 0; i < DEPTH - 1; i++) begin
            shift_c[i] = win_q[i + 1];
        end
        shift_c[DEPTH - 1] = bus_io.in_data;
    end

    // Next window, fill count and strobe.
    always_comb begin
        win_d   = win_q;
        fill_d  = fill_q;
        valid_d = 1'b0;
        if (bus_io.flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                win_d[i] = '0;
            end
            fill_d = '0;
            if (bus_io.in_valid) begin
                if (REPLICATE) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        win_d[i] = bus_io.in_data;
                    end
                    fill_d  = CNT_FULL;
                    valid_d = 1'b1;
                end else begin
                    win_d[DEPTH - 1] = bus_io.in_data;
                    fill_d           = CNT_W'(1);
                end
            end
        end else if (bus_io.in_valid) begin
            case (state_q)
                ST_IDLE: begin
                    if (REPLICATE) begin
                        for (int i = 0; i < DEPTH; i++) begin
                            win_d[i] = bus_io.in_data;
                        end
                        fill_d  = CNT_FULL;
                        valid_d = 1'b1;
                    end else begin
                        win_d  = shift_c;
                        fill_d = CNT_W'(1);
                    end
                end
                ST_FILL: begin
                    win_d   = shift_c;
                    fill_d  = fill_q + CNT_W'(1);
                    valid_d = (fill_q == CNT_LAST);
                end
                ST_FULL: begin
                    win_d   = shift_c;
                    fill_d  = CNT_FULL;
                    valid_d = 1'b1;
                end
                default: begin
                    win_d = win_q;
                end
            endcase
        end
    end

    // Window, count and strobe registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                win_q[i] <= '0;
            end
            fill_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            win_q   <= win_d;
            fill_q  <= fill_d;
            valid_q <= valid_d;
        end
    end

    assign bus_io.out_num0  = win_q[0];
    assign bus_io.out_num1  = win_q[1];
    assign bus_io.out_num2  = win_q[2];
    assign bus_io.out_num3  = win_q[3];
    assign bus_io.out_num4  = win_q[4];
    assign bus_io.fill_cnt  = fill_q;
    assign bus_io.out_valid = valid_q;

endmodule

// File: tb/tb_median_window_buf.sv
// Bench for median_window_buf: directed plan followed by random samples/flushes/resets,
// checked every cycle against a sample-history model.
module tb_median_window_buf;

`ifdef MEDIAN_EDGE_REPLICATE_EN
    localparam bit REP = 1'b1;
`else
    localparam bit REP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;

    // Model: samples accepted since the last reset/flush (only the newest 5 kept).
    int   hist[$];
    bit   exp_valid;

    median_window_buf_if #(.DATA_W(6)) bus ();

    median_window_buf #(.DATA_W(6)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_io (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_update(input bit r, input bit v, input int d, input bit f);
        exp_valid = 1'b0;
        if (!r) begin
            hist.delete();
        end else if (f || v) begin
            if (f) hist.delete();
            if (v) begin
                if (REP && hist.size() == 0) begin
                    for (int k = 0; k < 5; k++) hist.push_back(d);
                end else begin
                    hist.push_back(d);
                end
                exp_valid = (hist.size() >= 5);
            end
            while (hist.size() > 5) void'(hist.pop_front());
        end
    endfunction

    function automatic logic [29:0] model_window();
        logic [29:0] w;
        int          idx;
        w = '0;
        for (int i = 0; i < 5; i++) begin
            idx = i - (5 - hist.size());
            if (idx >= 0) w[(4 - i) * 6 +: 6] = 6'(hist[idx]);
        end
        return w;
    endfunction

    function automatic logic [29:0] dut_window();
        return {bus.out_num0, bus.out_num1, bus.out_num2, bus.out_num3, bus.out_num4};
    endfunction

    // One clock: drive at negedge, advance the model at posedge, compare just after.
    task automatic step(input bit r, input bit v, input logic [5:0] d, input bit f);
        @(negedge clk);
        rst_n        = r;
        bus.in_valid = v;
        bus.in_data  = d;
        bus.flush    = f;
        @(posedge clk);
        model_update(r, v, int'(d), f);
        #1;
        check("out_valid", 32'(bus.out_valid), 32'(exp_valid));
        check("fill_cnt", 32'(bus.fill_cnt), 32'(hist.size()));
        check("window", 32'(dut_window()), 32'(model_window()));
    endtask

    initial begin
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.flush    = 1'b0;

        // Reset with a sample present: it must be discarded.
        step(1'b0, 1'b1, 6'd33, 1'b0);
        step(1'b0, 1'b1, 6'd33, 1'b0);
        check("rst_window", 32'(dut_window()), 32'd0);
        step(1'b1, 1'b0, 6'd0, 1'b0);

        // Start-up from empty: 25 then 3, then clear.
        step(1'b1, 1'b1, 6'd25, 1'b0);
`ifdef MEDIAN_EDGE_REPLICATE_EN
        check("rep_first_valid", 32'(bus.out_valid), 32'd1);
        check("rep_first_win", 32'(dut_window()), 32'({6'd25, 6'd25, 6'd25, 6'd25, 6'd25}));
`endif
        step(1'b1, 1'b1, 6'd3, 1'b0);
`ifdef MEDIAN_EDGE_REPLICATE_EN
        check("rep_second_win", 32'(dut_window()), 32'({6'd25, 6'd25, 6'd25, 6'd25, 6'd3}));
`endif
        step(1'b1, 1'b0, 6'd0, 1'b1);

        // Fill 10..50 back to back.
        for (int i = 1; i <= 5; i++) step(1'b1, 1'b1, 6'(i * 10), 1'b0);
`ifndef MEDIAN_EDGE_REPLICATE_EN
        check("dir_fill_valid", 32'(bus.out_valid), 32'd1);
        check("dir_fill_win", 32'(dut_window()), 32'({6'd10, 6'd20, 6'd30, 6'd40, 6'd50}));
`endif
        // Steady state.
        step(1'b1, 1'b1, 6'd63, 1'b0);
        step(1'b1, 1'b1, 6'd0, 1'b0);
`ifndef MEDIAN_EDGE_REPLICATE_EN
        check("dir_steady_win", 32'(dut_window()), 32'({6'd30, 6'd40, 6'd50, 6'd63, 6'd0}));
`endif
        // Gapped samples.
        step(1'b1, 1'b1, 6'd7, 1'b0);
        step(1'b1, 1'b0, 6'd55, 1'b0);
        step(1'b1, 1'b0, 6'd55, 1'b0);
        step(1'b1, 1'b1, 6'd8, 1'b0);
        step(1'b1, 1'b0, 6'd55, 1'b0);
        step(1'b1, 1'b0, 6'd55, 1'b0);

        // Flush colliding with a sample, then four more.
        step(1'b1, 1'b1, 6'd9, 1'b1);
`ifndef MEDIAN_EDGE_REPLICATE_EN
        check("dir_flush_win", 32'(dut_window()), 32'd9);
        check("dir_flush_fill", 32'(bus.fill_cnt), 32'd1);
`endif
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 6'(i + 1), 1'b0);

        // Random traffic with occasional flush and reset.
        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(99) >= 2), ($urandom_range(99) < 60),
                 6'($urandom_range(63)), ($urandom_range(99) < 5));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/median_window_buf.md
Name: median_window_buf

Overview:
- Upstream stage of the 5-input median sorter.
- Takes a serial stream of 6-bit samples and keeps a registered 5-deep sliding window.
- Presents the window as five parallel words (out_num0 oldest .. out_num4 newest) with a one-cycle out_valid strobe per new window, for direct connection to the sorter's in_num0..in_num4.
- Provides fill tracking, flush, and an optional edge-replication start-up mode.

Parameters:
- DATA_W, 6, sample width in bits. Window depth is fixed at 5.

Ports:
- clk       input   1       rising-edge clock
- rst_n     input   1       synchronous active-low reset, sampled on rising clk
- in_valid  input   1       in_data is a new sample this cycle
- in_data   input   DATA_W  sample value, unsigned
- flush     input   1       discard window contents, return to IDLE
- out_valid output  1       one-cycle strobe: out_num0..4 hold a new complete window
- out_num0  output  DATA_W  oldest sample in window
- out_num1  output  DATA_W  window entry 1
- out_num2  output  DATA_W  window entry 2
- out_num3  output  DATA_W  window entry 3
- out_num4  output  DATA_W  newest sample in window
- fill_cnt  output  3       number of valid entries, 0..5

Behaviour:
- Clock and reset: one clock domain (clk). Reset is synchronous, active-low (rst_n). While rst_n=0 at a rising edge:
  - out_num0..4 = 0, out_valid = 0, fill_cnt = 0, state = IDLE.
- All outputs are registered; there is no combinational in->out path.
- Shift rule: on an accepted sample, in one cycle:
  - out_num0<=out_num1, out_num1<=out_num2, out_num2<=out_num3, out_num3<=out_num4, out_num4<=in_data.
- No sample accepted: out_num0..4 hold their values.
- FSM states:
  - IDLE (fill_cnt=0): in_valid -> FILL, fill_cnt=1.
  - FILL (fill_cnt 1..4): each in_valid increments fill_cnt. When fill_cnt goes 4->5 -> FULL.
  - FULL (fill_cnt=5): each in_valid shifts; fill_cnt saturates at 5 and never wraps.
- out_valid timing:
  - Asserted in the cycle after the edge at which fill_cnt becomes 5 (i.e. the 5th accepted sample).
  - Asserted again in the cycle after every subsequent accepted sample in FULL.
  - Otherwise 0. Latency from in_valid to out_valid is 1 cycle.
- Back-to-back in_valid produces back-to-back out_valid. Gaps in in_valid hold the window and keep out_valid low.
- Entries not yet filled keep their previous contents (0 after reset/flush). Downstream must ignore the window unless out_valid=1.
- flush=1 (rst_n=1):
  - out_num0..4 = 0, fill_cnt = 0, out_valid = 0.
  - Next state is IDLE, from any state.
- flush and in_valid in the same cycle: flush wins for the old contents.
  - The concurrent sample is loaded as the first sample of the new window: out_num4=in_data, others 0, fill_cnt=1, state FILL, out_valid=0.
- rst_n=0 during FILL/FULL: same as reset above. A sample presented with rst_n=0 is discarded.
- No backpressure: the downstream sorter is combinational and always consumes.

Optional Feature:
- Macro: MEDIAN_EDGE_REPLICATE_EN.
- Defined:
  - The first accepted sample after reset/flush writes in_data into all five entries, fill_cnt becomes 5, state goes directly to FULL, and out_valid pulses the next cycle.
  - Result: one output window per input sample from the first one, with left-edge replication.
  - flush plus in_valid in the same cycle: all five entries = in_data, fill_cnt=5, FULL, out_valid pulses the next cycle.
- Not defined: behaviour exactly as in Behaviour. No output until 5 samples.

Test Plan:
- Reset: drive rst_n=0 for 2 cycles with in_valid=1, in_data=6'd33 -> all out_num=0, fill_cnt=0, out_valid=0 during and after reset.
- Fill: samples 10,20,30,40,50 back-to-back ->
  - fill_cnt steps 1..5;
  - out_valid=0 for the first 4 outputs, then one cycle after sample 50: out_valid=1 with out_num0..4 = 10,20,30,40,50.
- Steady state: continue with 63, 0 back-to-back ->
  - windows 20,30,40,50,63 then 30,40,50,63,0;
  - out_valid high on both consecutive cycles; fill_cnt stays 5.
- Gaps: in FULL, in_valid=1 every 3rd cycle with 7, 8 -> out_valid single-cycle pulses one cycle after each sample; window held unchanged between pulses.
- Flush collision: in FULL, flush=1 and in_valid=1 with in_data=9 -> next cycle out_num0..3=0, out_num4=9, fill_cnt=1, out_valid=0. Four more samples then yield out_valid=1.
- Replicate (MEDIAN_EDGE_REPLICATE_EN defined): after reset, a single sample 25 -> next cycle out_valid=1, all out_num=25, fill_cnt=5. Then sample 3 -> 25,25,25,25,3 with out_valid=1.
